// File: rtl/m_pcpi_pkg.sv
// Shared RV32M decode constants, issue-FSM states and PCPI request payload
// for the core-side PCPI initiator.
package m_pcpi_pkg;

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ISSUE_IDLE  = 2'd0,
    ISSUE_REQ   = 2'd1,
    ISSUE_WB    = 2'd2,
    ISSUE_DRAIN = 2'd3
  } issue_state_e;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } pcpi_req_t;

  function automatic logic is_m_insn(input logic [31:0] insn);
    return (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNC7_MULDIV);
  endfunction

endpackage

// File: rtl/m_pcpi_issue_if.sv
// PCPI request/response bus between the core (master) and a coprocessor (slave).
interface m_pcpi_issue_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_busy;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_ready, pcpi_wr, pcpi_rd, pcpi_busy
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_ready, pcpi_wr, pcpi_rd, pcpi_busy
  );
endinterface

// File: rtl/m_pcpi_watchdog.sv
// Counts idle request cycles (no busy, no ready) and flags expiry; once the
// coprocessor has shown busy in the current request the count freezes.
module m_pcpi_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_c,
  input  logic active_c,
  input  logic pcpi_busy,
  input  logic pcpi_ready,
  output logic expire_c
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;
  logic          busy_seen_q, busy_seen_d;
  logic          idle_c;

  assign idle_c   = active_c && !busy_seen_q && !pcpi_busy && !pcpi_ready;
  assign expire_c = idle_c && (count_q == LAST);

  always_comb begin
    count_d     = count_q;
    busy_seen_d = busy_seen_q;
    if (clear_c) begin
      count_d     = '0;
      busy_seen_d = 1'b0;
    end else begin
      if (active_c && pcpi_busy) busy_seen_d = 1'b1;
      if (idle_c && (count_q != LAST)) count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      busy_seen_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      busy_seen_q <= busy_seen_d;
    end
  end

endmodule

// File: rtl/m_pcpi_issue.sv
// Core-side PCPI initiator: issues RV32M ops from EX, stalls until the answer,
// drains stale responses after flush. Optional request timeout: PCPI_TIMEOUT_EN.
module m_pcpi_issue
  import m_pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ex_valid,
  input  logic [31:0]   ex_instruction,
  input  logic [31:0]   ex_rs1,
  input  logic [31:0]   ex_rs2,
  input  logic [4:0]    ex_rd_addr,
  input  logic          flush,
  m_pcpi_issue_if.master pcpi,
  output logic          m_stall,
  output logic          m_done,
  output logic          wb_valid,
  output logic [4:0]    wb_rd_addr,
  output logic [31:0]   wb_data,
  output logic          illegal_insn
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("m_pcpi_issue: TIMEOUT_CYCLES must be >= 2");
  end

  issue_state_e state_q, state_d;
  pcpi_req_t    req_q, req_d;
  logic [4:0]   rd_q, rd_d;
  logic [31:0]  res_q, res_d;
  logic         wr_q, wr_d;
  logic         start_c, ex_is_m_c, pcpi_valid_c, expire_c;

  assign ex_is_m_c = ex_valid && is_m_insn(ex_instruction);
  assign start_c   = ex_is_m_c && !flush;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    rd_d         = rd_q;
    res_d        = res_q;
    wr_d         = wr_q;
    pcpi_valid_c = 1'b0;
    m_stall      = 1'b0;
    m_done       = 1'b0;
    wb_valid     = 1'b0;
    illegal_insn = 1'b0;
    unique case (state_q)
      ISSUE_IDLE: begin
        if (start_c) begin
          req_d   = '{insn: ex_instruction, rs1: ex_rs1, rs2: ex_rs2};
          rd_d    = ex_rd_addr;
          m_stall = 1'b1;
          state_d = ISSUE_REQ;
        end
      end
      ISSUE_REQ: begin
        pcpi_valid_c = 1'b1;
        m_stall      = 1'b1;
        if (pcpi.pcpi_ready) begin
          if (flush) begin
            state_d = ISSUE_IDLE;
          end else begin
            res_d   = pcpi.pcpi_rd;
            wr_d    = pcpi.pcpi_wr;
            state_d = ISSUE_WB;
          end
        end else if (flush) begin
          state_d = ISSUE_DRAIN;
        end else if (expire_c) begin
          // Unresponsive coprocessor: trap and release the pipeline.
          illegal_insn = 1'b1;
          pcpi_valid_c = 1'b0;
          m_stall      = 1'b0;
          state_d      = ISSUE_IDLE;
        end
      end
      ISSUE_WB: begin
        if (!flush) begin
          m_done   = 1'b1;
          wb_valid = wr_q && (rd_q != 5'd0);
        end
        state_d = ISSUE_IDLE;
      end
      ISSUE_DRAIN: begin
        // Only a new M op must wait for the stale response to clear.
        m_stall = ex_is_m_c;
        if (pcpi.pcpi_ready || expire_c) state_d = ISSUE_IDLE;
      end
      default: state_d = ISSUE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ISSUE_IDLE;
      req_q   <= '0;
      rd_q    <= 5'd0;
      res_q   <= 32'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
    end
  end

  assign pcpi.pcpi_valid = pcpi_valid_c;
  assign pcpi.pcpi_insn  = req_q.insn;
  assign pcpi.pcpi_rs1   = req_q.rs1;
  assign pcpi.pcpi_rs2   = req_q.rs2;
  assign wb_rd_addr      = rd_q;
  assign wb_data         = res_q;

`ifdef PCPI_TIMEOUT_EN
  logic wd_active_c, wd_clear_c;

  assign wd_active_c = (state_q == ISSUE_REQ) || (state_q == ISSUE_DRAIN);
  assign wd_clear_c  = (state_d != state_q) &&
                       ((state_d == ISSUE_REQ) || (state_d == ISSUE_DRAIN));

  m_pcpi_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (resetn),
    .clear_c   (wd_clear_c),
    .active_c  (wd_active_c),
    .pcpi_busy (pcpi.pcpi_busy),
    .pcpi_ready(pcpi.pcpi_ready),
    .expire_c  (expire_c)
  );
`else
  assign expire_c = 1'b0;
`endif

endmodule

// File: tb/tb_m_pcpi_issue.sv
// Directed self-checking bench for m_pcpi_issue; the timeout scenario is
// exercised only when PCPI_TIMEOUT_EN is defined.
module tb_m_pcpi_issue;

  logic        clk;
  logic        resetn;
  logic        ex_valid;
  logic [31:0] ex_instruction;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [4:0]  ex_rd_addr;
  logic        flush;
  logic        m_stall;
  logic        m_done;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        illegal_insn;

  int n_chk  = 0;
  int n_pass = 0;

  m_pcpi_issue_if pcpi_bus ();

  m_pcpi_issue #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .ex_valid      (ex_valid),
    .ex_instruction(ex_instruction),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd_addr    (ex_rd_addr),
    .flush         (flush),
    .pcpi          (pcpi_bus),
    .m_stall       (m_stall),
    .m_done        (m_done),
    .wb_valid      (wb_valid),
    .wb_rd_addr    (wb_rd_addr),
    .wb_data       (wb_data),
    .illegal_insn  (illegal_insn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] r_insn(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  // Reference coprocessor arithmetic applied to whatever the bus presents.
  function automatic logic [31:0] resp_calc(input logic [31:0] insn, input logic [31:0] a,
                                            input logic [31:0] b);
    case (insn[14:12])
      3'd0:    return a * b;
      3'd4:    return 32'($signed(a) / $signed(b));
      3'd5:    return a / b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    pcpi_bus.pcpi_busy  = 1'b0;
    pcpi_bus.pcpi_ready = 1'b0;
    pcpi_bus.pcpi_wr    = 1'b0;
    pcpi_bus.pcpi_rd    = 32'd0;
  endtask

  task automatic present(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    ex_valid       = 1'b1;
    ex_instruction = insn;
    ex_rs1         = a;
    ex_rs2         = b;
    ex_rd_addr     = rd;
  endtask

  // Full M op: issue cycle, lat REQ cycles (ready on the last), then WB.
  task automatic do_op(input string name, input logic [31:0] insn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input int lat,
                       input logic [31:0] exp_data, input logic exp_wbv, input logic wb_flush);
    present(insn, a, b, rd);
    #1;
    check({name, ".issue_stall"}, 32'(m_stall), 32'd1);
    check({name, ".issue_pvalid"}, 32'(pcpi_bus.pcpi_valid), 32'd0);
    check({name, ".issue_done"}, 32'(m_done), 32'd0);
    next_cycle();
    for (int c = 1; c <= lat; c++) begin
      pcpi_bus.pcpi_busy  = (c < lat);
      pcpi_bus.pcpi_ready = (c == lat);
      pcpi_bus.pcpi_wr    = (c == lat);
      pcpi_bus.pcpi_rd    = (c == lat) ?
          resp_calc(pcpi_bus.pcpi_insn, pcpi_bus.pcpi_rs1, pcpi_bus.pcpi_rs2) : 32'd0;
      #1;
      check({name, ".req_pvalid"}, 32'(pcpi_bus.pcpi_valid), 32'd1);
      check({name, ".req_stall"}, 32'(m_stall), 32'd1);
      check({name, ".req_insn"}, pcpi_bus.pcpi_insn, insn);
      check({name, ".req_rs1"}, pcpi_bus.pcpi_rs1, a);
      check({name, ".req_rs2"}, pcpi_bus.pcpi_rs2, b);
      check({name, ".req_trap"}, 32'(illegal_insn), 32'd0);
      next_cycle();
    end
    bus_idle();
    flush = wb_flush;
    #1;
    check({name, ".wb_pvalid"}, 32'(pcpi_bus.pcpi_valid), 32'd0);
    check({name, ".wb_stall"}, 32'(m_stall), 32'd0);
    check({name, ".wb_done"}, 32'(m_done), 32'(!wb_flush));
    check({name, ".wb_valid"}, 32'(wb_valid), 32'(exp_wbv && !wb_flush));
    check({name, ".wb_rd"}, 32'(wb_rd_addr), 32'(rd));
    check({name, ".wb_data"}, wb_data, exp_data);
    next_cycle();
    flush    = 1'b0;
    ex_valid = 1'b0;
    #1;
    check({name, ".post_pvalid"}, 32'(pcpi_bus.pcpi_valid), 32'd0);
    check({name, ".post_done"}, 32'(m_done), 32'd0);
  endtask

  localparam logic [6:0] F7M = 7'b0000001;
  logic [31:0] mul_x5, divu_x6, div_x7, mul_x3, mul_x0, add_x4;

  initial begin
    mul_x5  = r_insn(F7M, 3'd0, 5'd5);
    divu_x6 = r_insn(F7M, 3'd5, 5'd6);
    div_x7  = r_insn(F7M, 3'd4, 5'd7);
    mul_x3  = r_insn(F7M, 3'd0, 5'd3);
    mul_x0  = r_insn(F7M, 3'd0, 5'd0);
    add_x4  = r_insn(7'd0, 3'd0, 5'd4);

    resetn = 1'b0;
    flush  = 1'b0;
    present(32'd0, 32'd0, 32'd0, 5'd0);
    ex_valid = 1'b0;
    bus_idle();
    repeat (2) next_cycle();
    check("rst.pvalid", 32'(pcpi_bus.pcpi_valid), 32'd0);
    check("rst.insn", pcpi_bus.pcpi_insn, 32'd0);
    check("rst.stall", 32'(m_stall), 32'd0);
    check("rst.done", 32'(m_done), 32'd0);
    check("rst.wbv", 32'(wb_valid), 32'd0);
    check("rst.wbdata", wb_data, 32'd0);
    check("rst.trap", 32'(illegal_insn), 32'd0);
    resetn = 1'b1;
    next_cycle();

    do_op("mul", mul_x5, 32'd7, 32'd6, 5'd5, 4, 32'd42, 1'b1, 1'b0);
    do_op("divu", divu_x6, 32'd100, 32'd7, 5'd6, 35, 32'd14, 1'b1, 1'b0);
    do_op("mul_rd0", mul_x0, 32'd3, 32'd5, 5'd0, 2, 32'd15, 1'b0, 1'b0);
    do_op("wb_flush", mul_x5, 32'd11, 32'd3, 5'd5, 2, 32'd33, 1'b1, 1'b1);

    // Flushed M op in IDLE must not issue.
    present(mul_x5, 32'd1, 32'd1, 5'd5);
    flush = 1'b1;
    #1;
    check("idle_flush.stall", 32'(m_stall), 32'd0);
    next_cycle();
    flush = 1'b0;
    ex_valid = 1'b0;
    #1;
    check("idle_flush.pvalid", 32'(pcpi_bus.pcpi_valid), 32'd0);
    next_cycle();

    // Flush mid-request -> DRAIN, stale answer dropped, then a fresh MUL.
    present(div_x7, 32'hFFFF_FFEC, 32'd3, 5'd7);
    next_cycle();
    pcpi_bus.pcpi_busy = 1'b1;
    next_cycle();
    next_cycle();
    flush = 1'b1;
    #1;
    check("drain.req3_pvalid", 32'(pcpi_bus.pcpi_valid), 32'd1);
    next_cycle();
    flush = 1'b0;
    present(add_x4, 32'd1, 32'd2, 5'd4);
    #1;
    check("drain.pvalid", 32'(pcpi_bus.pcpi_valid), 32'd0);
    check("drain.nonm_stall", 32'(m_stall), 32'd0);
    check("drain.rs1_held", pcpi_bus.pcpi_rs1, 32'hFFFF_FFEC);
    next_cycle();
    present(mul_x3, 32'd9, 32'd8, 5'd3);
    #1;
    check("drain.m_stall", 32'(m_stall), 32'd1);
    next_cycle();
    pcpi_bus.pcpi_busy  = 1'b0;
    pcpi_bus.pcpi_ready = 1'b1;
    pcpi_bus.pcpi_wr    = 1'b1;
    pcpi_bus.pcpi_rd    = 32'hDEAD_BEEF;
    #1;
    check("drain.ready_stall", 32'(m_stall), 32'd1);
    check("drain.ready_done", 32'(m_done), 32'd0);
    next_cycle();
    bus_idle();
    check("drain.after_wbv", 32'(wb_valid), 32'd0);
    do_op("drain_mul", mul_x3, 32'd9, 32'd8, 5'd3, 3, 32'd72, 1'b1, 1'b0);

    // Flush coincident with ready: back to IDLE, nothing written.
    present(mul_x5, 32'd2, 32'd2, 5'd5);
    next_cycle();
    pcpi_bus.pcpi_busy = 1'b1;
    next_cycle();
    pcpi_bus.pcpi_busy  = 1'b0;
    pcpi_bus.pcpi_ready = 1'b1;
    pcpi_bus.pcpi_wr    = 1'b1;
    pcpi_bus.pcpi_rd    = 32'd4;
    flush = 1'b1;
    next_cycle();
    bus_idle();
    flush    = 1'b0;
    ex_valid = 1'b0;
    #1;
    check("fr.done", 32'(m_done), 32'd0);
    check("fr.wbv", 32'(wb_valid), 32'd0);
    check("fr.pvalid", 32'(pcpi_bus.pcpi_valid), 32'd0);
    check("fr.stall", 32'(m_stall), 32'd0);
    check("fr.data", wb_data, 32'd72);
    next_cycle();

    // Asynchronous reset in the middle of a request.
    present(mul_x5, 32'd5, 32'd5, 5'd5);
    next_cycle();
    pcpi_bus.pcpi_busy = 1'b1;
    next_cycle();
    resetn   = 1'b0;
    ex_valid = 1'b0;
    #1;
    check("mrst.pvalid", 32'(pcpi_bus.pcpi_valid), 32'd0);
    check("mrst.insn", pcpi_bus.pcpi_insn, 32'd0);
    check("mrst.rs1", pcpi_bus.pcpi_rs1, 32'd0);
    check("mrst.stall", 32'(m_stall), 32'd0);
    check("mrst.data", wb_data, 32'd0);
    check("mrst.rd", 32'(wb_rd_addr), 32'd0);
    bus_idle();
    next_cycle();
    resetn = 1'b1;
    next_cycle();

    // Long DIV with busy asserted must never trap.
    do_op("div40", div_x7, 32'd400, 32'd9, 5'd7, 40, 32'd44, 1'b1, 1'b0);

`ifdef PCPI_TIMEOUT_EN
    // Silent coprocessor: trap on REQ cycle 16.
    present(mul_x5, 32'd1, 32'd2, 5'd5);
    next_cycle();
    for (int c = 1; c < 16; c++) begin
      check("to.wait_trap", 32'(illegal_insn), 32'd0);
      check("to.wait_pvalid", 32'(pcpi_bus.pcpi_valid), 32'd1);
      next_cycle();
    end
    check("to.trap", 32'(illegal_insn), 32'd1);
    check("to.stall", 32'(m_stall), 32'd0);
    check("to.pvalid", 32'(pcpi_bus.pcpi_valid), 32'd0);
    check("to.done", 32'(m_done), 32'd0);
    next_cycle();
    ex_valid = 1'b0;
    #1;
    check("to.after_trap", 32'(illegal_insn), 32'd0);
    check("to.after_pvalid", 32'(pcpi_bus.pcpi_valid), 32'd0);
    next_cycle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/m_pcpi_issue.md
Name: m_pcpi_issue

Overview:
- Core-side initiator of the PCPI handshake; the counterpart of the M-extension coprocessor.
- Sits in EX and detects RV32M instructions (opcode 0110011, func7 0000001).
- Registers and holds the instruction and operands on the PCPI bus, stalls the pipeline until the coprocessor answers, then produces a one-cycle write-back.
- Handles pipeline flush while a request is in flight by draining the coprocessor's stale response.

Parameters:
- TIMEOUT_CYCLES, 16: REQ cycles with neither pcpi_busy nor pcpi_ready before a trap is raised. Only used with the optional feature. Must be >= 2.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a valid instruction
- ex_instruction  in  32  EX instruction word
- ex_rs1, ex_rs2  in  32  forwarded operand values
- ex_rd_addr  in  5  destination register
- flush  in  1  kill the EX instruction and any in-flight request
- pcpi_valid  out  1  request valid
- pcpi_insn  out  32  registered instruction
- pcpi_rs1, pcpi_rs2  out  32  registered operands
- pcpi_ready  in  1  coprocessor result valid (one-cycle pulse)
- pcpi_wr  in  1  result is to be written
- pcpi_rd  in  32  result data
- pcpi_busy  in  1  coprocessor working
- m_stall  out  1  hold IF/ID/EX
- m_done  out  1  completion pulse
- wb_valid  out  1  write wb_data to wb_rd_addr
- wb_rd_addr  out  5  destination register
- wb_data  out  32  result
- illegal_insn  out  1  timeout trap pulse

Behaviour:
- Reset (resetn=0, async): state IDLE; all outputs and registers 0. Reset mid-operation abandons the request. The coprocessor shares the same reset.
- start = ex_valid && is_m_insn(ex_instruction) && !flush.
- IDLE:
  - On start: capture insn/rs1/rs2/rd into output registers and go to REQ. m_stall=1 combinationally in this cycle.
  - pcpi_valid rises the next cycle.
- REQ:
  - pcpi_valid=1 and m_stall=1. pcpi_insn/rs1/rs2 are held stable through the pcpi_ready cycle, because the responder re-reads operands when finishing.
  - pcpi_ready && !flush: latch pcpi_rd and pcpi_wr, go to WB.
  - flush && pcpi_ready (same cycle): discard the result, go to IDLE.
  - flush && !pcpi_ready: go to DRAIN.
- WB (one cycle):
  - pcpi_valid=0, so the responder sees no re-issue on its return to IDLE. m_stall=0.
  - m_done=1. wb_valid = latched_wr && rd!=0. wb_data = latched result.
  - flush in WB suppresses m_done and wb_valid.
  - Next state IDLE. A back-to-back M instruction is accepted in the following IDLE cycle, so two M ops are spaced at least 2 cycles apart on the bus.
- DRAIN:
  - pcpi_valid=0; operands stay held.
  - m_stall = ex_valid && is_m_insn(ex_instruction). Non-M instructions flow freely.
  - On pcpi_ready: drop the result, go to IDLE. No m_done.
- Latency: bus request at issue+1. The write-back pulse comes the cycle after pcpi_ready.
- Timing constraint: pcpi_ready must never be sampled in IDLE or WB. If it is, it is ignored.

Optional Feature:
- Macro: PCPI_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entering REQ or DRAIN.
  - It increments each cycle with !pcpi_busy && !pcpi_ready.
  - It freezes permanently once pcpi_busy has been seen in the current request.
  - In REQ, when the count reaches TIMEOUT_CYCLES-1 with no busy/ready: illegal_insn=1 for one cycle, m_stall=0, pcpi_valid=0, go to IDLE. No m_done.
  - In DRAIN, the same expiry goes silently to IDLE.
- Without the macro: no counter is built, illegal_insn is tied 0, and REQ/DRAIN wait indefinitely.

Decomposition:
- Shared package m_pcpi_pkg holds:
  - OPCODE/FUNC7 constants, reusing the existing M definitions
  - the issue state enum (IDLE, REQ, WB, DRAIN)
  - the is_m_insn() function
- One sub-module, m_pcpi_watchdog (counter + busy-seen flag + expire output), instantiated only under PCPI_TIMEOUT_EN.

Test Plan:
- MUL x5, rs1=7, rs2=6, responder answers after 4 cycles -> pcpi_valid at issue+1; m_stall high from issue through the ready cycle; next cycle wb_valid=1, wb_rd_addr=5, wb_data=42.
- DIVU rs1=100, rs2=7, 35-cycle responder -> pcpi_rs1/rs2 constant until ready; pcpi_valid=0 the cycle after ready; no second issue; wb_data=14.
- DIV in flight, flush at REQ cycle 3, then MUL presented -> DRAIN, MUL stalled, stale ready discarded (no m_done); MUL issued next IDLE and yields the correct product.
- flush coincident with pcpi_ready -> IDLE; wb_valid and m_done stay 0. Separately, resetn low mid-REQ -> all outputs 0 immediately.
- MUL with rd=0 -> m_done=1, wb_valid=0.
- PCPI_TIMEOUT_EN, TIMEOUT_CYCLES=16, busy/ready tied 0 -> illegal_insn pulse on REQ cycle 16, stall released, pcpi_valid low. A 40-cycle DIV with busy asserted does not trap.
